// File: rtl/pl_pkg.sv
// Shared definitions for the memory/writeback stage: EX bundle field
// indices, the memory-interface FSM state type and the RNS lane width.
package pl_pkg;

  // Width of one RNS lane and of the integer datapath.
  localparam int LANE_W = 8;

  // Field positions inside the EX pipeline register bundle. Field 0 is the
  // leftmost (most significant) bit of the 8-bit vector.
  typedef enum logic [2:0] {
    EXR_STORE       = 3'd0,
    EXR_REG_WR_EN   = 3'd1,
    EXR_SAVE_COUT   = 3'd2,
    EXR_INV_EXECUTE = 3'd3,
    EXR_LOAD        = 3'd4,
    EXR_INV_FETCH   = 3'd5,
    EXR_INV_DECODE  = 3'd6,
    EXR_DEST_RNS    = 3'd7
  } exr_idx_t;

  // Memory handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    LD_WAIT = 2'd2
  } mem_state_t;

  // Extract one named field from the EX bundle.
  function automatic logic exr_bit(input logic [7:0] ex_reg, input exr_idx_t idx);
    return ex_reg[3'd7 - idx];
  endfunction

endpackage

// File: rtl/pl_mem_if.sv
// Data-memory req/ack interface for pl_mem_wb: captures address/data on a
// load or store, holds the request stable until mem_ack, tracks the load
// destination and drives the registered stall.
module pl_mem_if
  import pl_pkg::*;
#(
  parameter int ADDR_WID = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_store,
  input  logic                i_load,
  input  logic [ADDR_WID-1:0] i_wr_addr,
  input  logic [ADDR_WID-1:0] i_rd_addr,
  input  logic [LANE_W-1:0]   i_wdata,
  input  logic [2:0]          i_dest,
  input  logic                i_mem_ack,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_WID-1:0] o_mem_addr,
  output logic [LANE_W-1:0]   o_mem_wdata,
  output logic                o_stall,
  output logic                o_idle,
  output logic                o_ld_done,
  output logic [2:0]          o_ld_dest
);

  mem_state_t          r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_WID-1:0] r_mem_addr;
  logic [LANE_W-1:0]   r_mem_wdata;
  logic                r_stall;
  logic [2:0]          r_ld_dest;

  // Request FSM: capture in IDLE, hold everything stable until mem_ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_stall     <= 1'b0;
      r_ld_dest   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (i_store) begin
            r_mem_addr  <= i_wr_addr;
            r_mem_wdata <= i_wdata;
            r_mem_we    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_stall     <= 1'b1;
            r_state     <= ST_WAIT;
          end else if (i_load) begin
            r_mem_addr  <= i_rd_addr;
            r_ld_dest   <= i_dest;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_stall     <= 1'b1;
            r_state     <= LD_WAIT;
          end
        end
        ST_WAIT, LD_WAIT: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_stall   <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_stall   <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_stall     = r_stall;
  assign o_idle      = (r_state == IDLE);
  // Load data is valid in the same cycle as the ack that ends LD_WAIT.
  assign o_ld_done   = (r_state == LD_WAIT) && i_mem_ack;
  assign o_ld_dest   = r_ld_dest;

endmodule

// File: rtl/pl_mem_wb.sv
// Memory/writeback pipeline stage. Consumes the EX bundle, issues loads and
// stores through pl_mem_if, drives the integer and RNS register-file write
// ports, keeps the architectural carry flag and stalls upstream while a
// memory access is outstanding.
// Optional build macro PL_MEM_WB_FWD_EN: when defined, fwd_* mirror the
// registered writeback port for the EX operand bypass; otherwise they are 0.
module pl_mem_wb
  import pl_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int ADDR_WID    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    EX_reg,
  input  logic [3:0]                    destination_reg_addr,
  input  logic [NUM_DOMAINS*LANE_W-1:0] operation_result,
  input  logic [ADDR_WID-1:0]           data_wr_addr,
  input  logic [ADDR_WID-1:0]           data_rd_addr,
  input  logic                          carry_in_EX,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WID-1:0]           mem_addr,
  output logic [LANE_W-1:0]             mem_wdata,
  input  logic [LANE_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic                          stall,
  output logic                          int_wr_en,
  output logic [2:0]                    int_wr_addr,
  output logic [LANE_W-1:0]             int_wr_data,
  output logic                          rns_wr_en,
  output logic [2:0]                    rns_wr_addr,
  output logic [NUM_DOMAINS*LANE_W-1:0] rns_wr_data,
  output logic                          carry_flag,
  output logic                          fwd_valid,
  output logic [3:0]                    fwd_addr,
  output logic [NUM_DOMAINS*LANE_W-1:0] fwd_data
);

  localparam int RES_W = NUM_DOMAINS * LANE_W;

  // Decoded EX bundle fields.
  logic w_valid;
  logic w_is_store;
  logic w_is_load;
  logic w_reg_wr;
  logic w_save_cout;

  assign w_valid     = !exr_bit(EX_reg, EXR_INV_EXECUTE);
  assign w_is_store  = exr_bit(EX_reg, EXR_STORE);
  assign w_is_load   = exr_bit(EX_reg, EXR_LOAD);
  assign w_reg_wr    = exr_bit(EX_reg, EXR_REG_WR_EN);
  assign w_save_cout = exr_bit(EX_reg, EXR_SAVE_COUT);

  // Store has priority when both memory bits are set.
  logic w_store_go;
  logic w_load_go;
  assign w_store_go = w_valid && w_is_store;
  assign w_load_go  = w_valid && w_is_load && !w_is_store;

  logic       w_idle;
  logic       w_ld_done;
  logic [2:0] w_ld_dest;

  pl_mem_if #(
    .ADDR_WID (ADDR_WID)
  ) u_mem_if (
    .clk         (clk),
    .reset       (reset),
    .i_store     (w_store_go),
    .i_load      (w_load_go),
    .i_wr_addr   (data_wr_addr),
    .i_rd_addr   (data_rd_addr),
    .i_wdata     (operation_result[LANE_W-1:0]),
    .i_dest      (destination_reg_addr[2:0]),
    .i_mem_ack   (mem_ack),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_stall     (stall),
    .o_idle      (w_idle),
    .o_ld_done   (w_ld_done),
    .o_ld_dest   (w_ld_dest)
  );

  // An instruction is consumed only while the memory interface is idle;
  // during a wait the EX bundle is frozen and looked at again afterwards.
  logic w_consume;
  logic w_alu_wr;
  assign w_consume = w_idle && w_valid;
  assign w_alu_wr  = w_consume && w_reg_wr && !w_is_store && !w_is_load;

  logic             r_int_wr_en;
  logic [2:0]       r_int_wr_addr;
  logic [LANE_W-1:0] r_int_wr_data;
  logic             r_rns_wr_en;
  logic [2:0]       r_rns_wr_addr;
  logic [RES_W-1:0] r_rns_wr_data;
  logic             r_carry_flag;

  // Registered writeback port: single-cycle enables, load data or ALU result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int_wr_en   <= 1'b0;
      r_int_wr_addr <= '0;
      r_int_wr_data <= '0;
      r_rns_wr_en   <= 1'b0;
      r_rns_wr_addr <= '0;
      r_rns_wr_data <= '0;
    end else begin
      r_int_wr_en <= 1'b0;
      r_rns_wr_en <= 1'b0;
      if (w_ld_done) begin
        // Loads always land in the integer file.
        r_int_wr_en   <= 1'b1;
        r_int_wr_addr <= w_ld_dest;
        r_int_wr_data <= mem_rdata;
      end else if (w_alu_wr) begin
        if (destination_reg_addr[3]) begin
          r_rns_wr_en   <= 1'b1;
          r_rns_wr_addr <= destination_reg_addr[2:0];
          r_rns_wr_data <= operation_result;
        end else begin
          r_int_wr_en   <= 1'b1;
          r_int_wr_addr <= destination_reg_addr[2:0];
          r_int_wr_data <= operation_result[LANE_W-1:0];
        end
      end
    end
  end

  // Architectural carry: updated only by a consumed valid save_cout instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carry_flag <= 1'b0;
    end else if (w_consume && w_save_cout) begin
      r_carry_flag <= carry_in_EX;
    end
  end

  assign int_wr_en   = r_int_wr_en;
  assign int_wr_addr = r_int_wr_addr;
  assign int_wr_data = r_int_wr_data;
  assign rns_wr_en   = r_rns_wr_en;
  assign rns_wr_addr = r_rns_wr_addr;
  assign rns_wr_data = r_rns_wr_data;
  assign carry_flag  = r_carry_flag;

`ifdef PL_MEM_WB_FWD_EN
  // Forwarding view of the writeback port for the EX operand bypass.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    fwd_valid = r_int_wr_en | r_rns_wr_en;
    fwd_addr  = {1'b0, r_int_wr_addr};
    fwd_data  = RES_W'(r_int_wr_data);
    if (r_rns_wr_en) begin
      fwd_addr = {1'b1, r_rns_wr_addr};
      fwd_data = r_rns_wr_data;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pl_mem_wb.sv
// Directed self-checking bench for pl_mem_wb.
module tb_pl_mem_wb;

  localparam int NUM_DOMAINS = 2;
  localparam int ADDR_WID    = 16;
  localparam int RES_W       = NUM_DOMAINS * 8;

`ifdef PL_MEM_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // EX bundle encodings; leftmost bit is field 0 (store).
  localparam logic [7:0] EX_NOP       = 8'b00000000;
  localparam logic [7:0] EX_ALU_WR    = 8'b01000000;
  localparam logic [7:0] EX_STORE     = 8'b10000000;
  localparam logic [7:0] EX_LOAD      = 8'b00001000;
  localparam logic [7:0] EX_SAVE_C    = 8'b00100000;
  localparam logic [7:0] EX_KILLED    = 8'b01110000;
  localparam logic [7:0] EX_ST_LD     = 8'b10001000;
  localparam logic [7:0] EX_KILLED_ST = 8'b10010000;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          EX_reg;
  logic [3:0]          destination_reg_addr;
  logic [RES_W-1:0]    operation_result;
  logic [ADDR_WID-1:0] data_wr_addr;
  logic [ADDR_WID-1:0] data_rd_addr;
  logic                carry_in_EX;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_WID-1:0] mem_addr;
  logic [7:0]          mem_wdata;
  logic [7:0]          mem_rdata;
  logic                mem_ack;
  logic                stall;
  logic                int_wr_en;
  logic [2:0]          int_wr_addr;
  logic [7:0]          int_wr_data;
  logic                rns_wr_en;
  logic [2:0]          rns_wr_addr;
  logic [RES_W-1:0]    rns_wr_data;
  logic                carry_flag;
  logic                fwd_valid;
  logic [3:0]          fwd_addr;
  logic [RES_W-1:0]    fwd_data;

  int n_tests = 0;
  int n_fail  = 0;

  pl_mem_wb #(
    .NUM_DOMAINS (NUM_DOMAINS),
    .ADDR_WID    (ADDR_WID)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .EX_reg               (EX_reg),
    .destination_reg_addr (destination_reg_addr),
    .operation_result     (operation_result),
    .data_wr_addr         (data_wr_addr),
    .data_rd_addr         (data_rd_addr),
    .carry_in_EX          (carry_in_EX),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .stall                (stall),
    .int_wr_en            (int_wr_en),
    .int_wr_addr          (int_wr_addr),
    .int_wr_data          (int_wr_data),
    .rns_wr_en            (rns_wr_en),
    .rns_wr_addr          (rns_wr_addr),
    .rns_wr_data          (rns_wr_data),
    .carry_flag           (carry_flag),
    .fwd_valid            (fwd_valid),
    .fwd_addr             (fwd_addr),
    .fwd_data             (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                = 1'b0;
    EX_reg               = EX_NOP;
    destination_reg_addr = 4'h0;
    operation_result     = '0;
    data_wr_addr         = '0;
    data_rd_addr         = '0;
    carry_in_EX          = 1'b0;
    mem_rdata            = 8'h00;
    mem_ack              = 1'b0;
    #1;

    // Reset state.
    check("rst_mem_req",   mem_req,    0);
    check("rst_stall",     stall,      0);
    check("rst_int_wr_en", int_wr_en,  0);
    check("rst_rns_wr_en", rns_wr_en,  0);
    check("rst_carry",     carry_flag, 0);
    check("rst_mem_addr",  mem_addr,   0);
    check("rst_fwd_valid", fwd_valid,  0);
    tick();
    tick();
    reset = 1'b1;

    // ALU writeback to integer file.
    EX_reg               = EX_ALU_WR;
    destination_reg_addr = 4'b0011;
    operation_result     = 16'h005A;
    tick();
    EX_reg = EX_NOP;
    check("alu_int_wr_en",   int_wr_en,   1);
    check("alu_int_wr_addr", int_wr_addr, 3);
    check("alu_int_wr_data", int_wr_data, 8'h5A);
    check("alu_rns_wr_en",   rns_wr_en,   0);
    check("alu_stall",       stall,       0);
    check("alu_fwd_valid",   fwd_valid,   FWD ? 1 : 0);
    check("alu_fwd_addr",    fwd_addr,    FWD ? 4'b0011 : 4'b0000);
    check("alu_fwd_data",    fwd_data,    FWD ? 16'h005A : 16'h0000);
    tick();
    check("alu_pulse_end", int_wr_en, 0);

    // Store with ack arriving in the fourth request cycle.
    EX_reg           = EX_STORE;
    data_wr_addr     = 16'h0120;
    data_rd_addr     = 16'h0BAD;
    operation_result = 16'h00C3;
    tick();
    EX_reg           = EX_NOP;
    data_wr_addr     = 16'hFFFF;
    operation_result = 16'h0011;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("st_req_c%0d", k),   mem_req,   1);
      check($sformatf("st_we_c%0d", k),    mem_we,    1);
      check($sformatf("st_addr_c%0d", k),  mem_addr,  16'h0120);
      check($sformatf("st_wdata_c%0d", k), mem_wdata, 8'hC3);
      check($sformatf("st_stall_c%0d", k), stall,     1);
      check($sformatf("st_nowr_c%0d", k),  int_wr_en | rns_wr_en, 0);
      if (k < 4) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_done_req",   mem_req,   0);
    check("st_done_stall", stall,     0);
    check("st_done_nowr",  int_wr_en, 0);

    // Ack while idle is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_req",   mem_req,   0);
    check("idle_ack_stall", stall,     0);
    check("idle_ack_wr",    int_wr_en, 0);

    // Load with immediate ack; destination bit 3 ignored.
    EX_reg               = EX_LOAD;
    data_rd_addr         = 16'h0456;
    destination_reg_addr = 4'b1101;
    tick();
    EX_reg = EX_NOP;
    check("ld_req",   mem_req,   1);
    check("ld_we",    mem_we,    0);
    check("ld_addr",  mem_addr,  16'h0456);
    check("ld_stall", stall,     1);
    check("ld_nowr",  int_wr_en, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h7E;
    tick();
    mem_ack = 1'b0;
    check("ld_int_wr_en",   int_wr_en,   1);
    check("ld_int_wr_addr", int_wr_addr, 5);
    check("ld_int_wr_data", int_wr_data, 8'h7E);
    check("ld_rns_wr_en",   rns_wr_en,   0);
    check("ld_done_stall",  stall,       0);
    check("ld_done_req",    mem_req,     0);
    tick();
    check("ld_pulse_end", int_wr_en, 0);

    // RNS writeback.
    EX_reg               = EX_ALU_WR;
    destination_reg_addr = 4'b1010;
    operation_result     = 16'h1234;
    tick();
    EX_reg = EX_NOP;
    check("rns_wr_en",     rns_wr_en,   1);
    check("rns_wr_addr",   rns_wr_addr, 2);
    check("rns_wr_data",   rns_wr_data, 16'h1234);
    check("rns_int_wr_en", int_wr_en,   0);
    check("rns_fwd_valid", fwd_valid,   FWD ? 1 : 0);
    check("rns_fwd_addr",  fwd_addr,    FWD ? 4'b1010 : 4'b0000);
    check("rns_fwd_data",  fwd_data,    FWD ? 16'h1234 : 16'h0000);

    // Carry capture, then killed instruction leaves carry and regfile alone.
    EX_reg      = EX_SAVE_C;
    carry_in_EX = 1'b1;
    tick();
    check("carry_set", carry_flag, 1);
    EX_reg               = EX_KILLED;
    carry_in_EX          = 1'b0;
    destination_reg_addr = 4'b0001;
    operation_result     = 16'h00AA;
    tick();
    check("kill_carry", carry_flag, 1);
    check("kill_int",   int_wr_en,  0);
    check("kill_rns",   rns_wr_en,  0);
    // Valid write without save_cout keeps the carry.
    EX_reg = EX_ALU_WR;
    tick();
    check("nosave_carry", carry_flag, 1);
    check("nosave_int",   int_wr_en,  1);
    // Clearing carry with a valid save_cout.
    EX_reg = EX_SAVE_C;
    tick();
    check("carry_clr", carry_flag, 0);
    // Killed store issues no request.
    EX_reg       = EX_KILLED_ST;
    data_wr_addr = 16'h0333;
    tick();
    check("kill_st_req",   mem_req, 0);
    check("kill_st_stall", stall,   0);

    // Store and load together: store wins.
    EX_reg       = EX_ST_LD;
    data_wr_addr = 16'h0200;
    data_rd_addr = 16'h0300;
    operation_result = 16'h0044;
    tick();
    EX_reg = EX_NOP;
    check("stld_we",   mem_we,   1);
    check("stld_addr", mem_addr, 16'h0200);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stld_nowr", int_wr_en, 0);
    check("stld_req",  mem_req,   0);

    // Reset during LD_WAIT abandons the load.
    EX_reg               = EX_LOAD;
    data_rd_addr         = 16'h0777;
    destination_reg_addr = 4'b0010;
    tick();
    EX_reg = EX_NOP;
    check("rld_stall_pre", stall, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rld_req",   mem_req,  0);
    check("rld_stall", stall,    0);
    check("rld_addr",  mem_addr, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h55;
    tick();
    reset = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rld_no_wr",  int_wr_en, 0);
    check("rld_req2",   mem_req,   0);
    check("rld_stall2", stall,     0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pl_mem_wb.md
Name: pl_mem_wb

Overview:
- Memory/writeback stage directly downstream of the execute stage.
- Consumes the EX pipeline register bundle, result and addresses.
- Runs a req/ack handshake to data memory for loads and stores.
- Drives register-file write ports for the integer file and the RNS file, holds the carry flag, and stalls upstream while a memory access is outstanding.

Parameters:
- NUM_DOMAINS, 2, number of RNS domains; RNS lanes are 8 bits each.
- ADDR_WID, 16, data-memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- EX_reg  in  8 [0:7]  {store, reg_wr_en, save_cout, invalidate_execute, load, invalidate_fetch, invalidate_decode, destination_RNS}
- destination_reg_addr  in  4  {RNS_file, addr[2:0]}
- operation_result  in  NUM_DOMAINS*8  result lanes; lane 0 = [7:0]
- data_wr_addr  in  ADDR_WID  store address
- data_rd_addr  in  ADDR_WID  load address
- carry_in_EX  in  1  ALU carry-out qualified in EX
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WID  memory address
- mem_wdata  out  8  store data
- mem_rdata  in  8  load data, valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  freezes PC/IFID/EX
- int_wr_en  out  1  integer regfile write enable
- int_wr_addr  out  3  integer regfile write address
- int_wr_data  out  8  integer regfile write data
- rns_wr_en  out  1  RNS regfile write enable
- rns_wr_addr  out  3  RNS regfile write address
- rns_wr_data  out  NUM_DOMAINS*8  RNS regfile write data
- carry_flag  out  1  architectural carry
- fwd_valid  out  1  forwarding valid (see Optional Feature)
- fwd_addr  out  4  forwarding address {RNS_file, addr[2:0]}
- fwd_data  out  NUM_DOMAINS*8  forwarding data

Behaviour:
- Reset (reset low, asynchronous): state IDLE, all outputs 0, carry_flag 0, latched address/data 0. Reset during a wait state abandons the access; no regfile write occurs and mem_req drops immediately.
- valid = !EX_reg[3]. Invalid instructions cause no write, no memory access and no carry update.
- FSM states: IDLE, ST_WAIT, LD_WAIT. stall = (state != IDLE), registered.
- IDLE, valid store (EX_reg[0]):
  - At the edge: latch mem_addr = data_wr_addr, mem_wdata = operation_result[7:0], mem_we = 1.
  - Assert mem_req and go to ST_WAIT.
- IDLE, valid load (EX_reg[4]):
  - At the edge: latch mem_addr = data_rd_addr and dest[2:0], mem_we = 0.
  - Assert mem_req and go to LD_WAIT.
- Store and load both set: store wins; the load is ignored.
- ST_WAIT / LD_WAIT:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - On the edge where mem_ack = 1: mem_req <= 0, state <= IDLE.
  - For a load, on that same edge: int_wr_en = 1, int_wr_addr = latched dest, int_wr_data = mem_rdata.
  - Loads always target the integer file; destination bit 3 is ignored.
- mem_ack while IDLE is ignored.
- The instruction presented by EX during a wait is consumed on the first IDLE cycle after the wait.
- Non-memory valid instruction with EX_reg[1] = 1: registered writeback, 1-cycle latency.
  - destination_reg_addr[3] = 0: int_wr_en = 1, int_wr_data = operation_result[7:0].
  - destination_reg_addr[3] = 1: rns_wr_en = 1, rns_wr_data = full operation_result.
  - Write enables are single-cycle pulses.
- Carry: if valid and EX_reg[2], carry_flag <= carry_in_EX at the consuming edge; otherwise carry_flag holds.
- Back-to-back memory operations: each costs 1 capture cycle plus the ack wait; no pipelining of requests.

Optional Feature:
- Macro: PL_MEM_WB_FWD_EN.
- Defined: the fwd_* outputs mirror the registered writeback port in the same cycle:
  - fwd_valid = int_wr_en | rns_wr_en.
  - fwd_addr = {rns_wr_en, address}.
  - fwd_data = int data zero-extended, or rns_wr_data.
  - Used by the EX operand bypass.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0; the ports remain present.

Decomposition:
- Shared package pl_pkg holds:
  - EX_reg bit index constants (EXR_STORE=0 … EXR_DEST_RNS=7);
  - the FSM state typedef (IDLE/ST_WAIT/LD_WAIT);
  - the lane width constant 8.
- One sub-module, pl_mem_if: the req/ack FSM, address/data latches and the stall output. The writeback mux and carry logic remain in the top module.

Test Plan:
- ALU writeback: operation_result 8'h5A, dest 4'b0011, EX_reg = 8'b01000000 -> next cycle int_wr_en = 1, int_wr_addr = 3, int_wr_data = 8'h5A; stall = 0.
- Store with 3-cycle ack delay: addr 16'h0120, data 8'hC3 -> mem_req held, mem_we = 1, mem_addr = 16'h0120, mem_wdata = 8'hC3 and stall = 1 for 4 cycles; no regfile write.
- Load with immediate ack (first mem_req cycle), mem_rdata 8'h7E, dest 5 -> int_wr_en pulse, int_wr_addr = 5, int_wr_data = 8'h7E; stall high for exactly 1 cycle.
- RNS writeback: dest 4'b1010, result 16'h1234 -> rns_wr_en = 1, rns_wr_addr = 2, rns_wr_data = 16'h1234; int_wr_en = 0.
- Carry and kill: save_cout = 1, carry_in_EX = 1 -> carry_flag = 1. Same instruction with EX_reg[3] = 1 -> carry_flag unchanged and no write.
- Reset low during LD_WAIT -> mem_req = 0 and stall = 0 immediately; a later mem_ack produces no int_wr_en.
